simd_stop_cmd_queue: RTL and testbench
======================================

Name: simd_stop_cmd_queue

Overview:
- Sits directly downstream of the PE SIMD wrapper's stOp regFile interface.
- SIMD core writes per-field staging registers, then a LAUNCH write.
- Each LAUNCH snapshots the staged fields, tags them, and queues them as one streamingOps command.
- The block issues commands to the streamingOps controller over valid/ready, tracks outstanding operations via completion pulses, and returns a status word to the SIMD.

Parameters:
- DATA_W, 32, width of each regFile field and of the status word.
- NUM_REGS, 4, number of staged command fields (opcode, src addr, dst addr, length).
- DEPTH, 4, command FIFO entries; power of 2, >=2.
- MAX_OUT, 4, maximum issued-but-incomplete commands; 1..255.
- TAG_W, 8, command sequence tag width.
- PE_ID_W, 6, peId width.

Ports:
- clk  in  1  system clock
- reset_poweron  in  1  asynchronous, active-low reset
- peId  in  PE_ID_W  static PE identifier, forwarded with each command
- simd__scntl__wr_valid  in  1  SIMD register write request
- simd__scntl__wr_ready  out  1  write accepted this cycle when both valid and ready are high
- simd__scntl__wr_addr  in  3  0..NUM_REGS-1 = field, 4 = LAUNCH, 7 = CLR_ERR, others illegal
- simd__scntl__wr_data  in  DATA_W  write data
- scntl__simd__status  out  DATA_W  [7:0] next tag, [15:8] queued count, [23:16] outstanding count, [31] err; other bits 0
- scntl__simd__busy  out  1  high when queued count != 0 or outstanding count != 0
- scntl__stop__cmd_valid  out  1  command available
- stop__scntl__cmd_ready  in  1  controller accepts command
- scntl__stop__cmd_data  out  NUM_REGS*DATA_W  packed fields; field 0 in the LSBs
- scntl__stop__cmd_tag  out  TAG_W  sequence tag
- scntl__stop__cmd_peId  out  PE_ID_W  peId
- stop__scntl__complete  in  1  one-cycle pulse per finished command

Behaviour:
- Reset (reset_poweron low, asynchronous):
  - Staging registers, FIFO pointers, tag counter, outstanding counter and err all go to 0.
  - cmd_valid = 0; busy = 0; status = 0.
  - wr_ready returns to 1 in the first cycle after reset is released.
  - A command in flight is discarded; any complete pulse during reset is ignored.
- wr_ready = !fifo_full. It stalls all addresses, not only LAUNCH, and does not depend on wr_addr.
- Field write (addr < NUM_REGS): the staging register updates at the accepting edge. A LAUNCH in the next cycle sees the new value.
- LAUNCH write:
  - Pushes {staging fields, tag} into the FIFO and increments the tag, wrapping 255 -> 0.
  - wr_data is ignored.
  - Staging registers keep their values, so repeated LAUNCHes re-issue the same fields with new tags.
- CLR_ERR write clears err. If an error event occurs in the same cycle, the set wins.
- Illegal address (5, 6): the write is accepted and has no effect other than setting err.
- Command issue:
  - cmd_valid = !fifo_empty && (outstanding < MAX_OUT).
  - Command outputs come from the registered FIFO head.
  - Outputs are stable while valid && !ready.
  - The handshake pops the FIFO and increments outstanding.
- Latency: a LAUNCH accepted at edge N gives cmd_valid high in the cycle after edge N, provided the FIFO was empty and outstanding < MAX_OUT.
- Full FIFO: a pop in the same cycle does not re-enable wr_ready until the next cycle (wr_ready is registered-full based).
- Completion:
  - A complete pulse decrements outstanding.
  - Handshake and complete in the same cycle leave outstanding unchanged.
  - A complete pulse while outstanding == 0 is ignored and sets err.
- Queued count = FIFO occupancy (0..DEPTH). Pointers are log2(DEPTH)+1 bits, so full and empty are distinguishable at wrap.
- Status and busy are registered: they reflect state as of the previous edge.

Decomposition:
- Shared header simd_stop_cmd.vh holds:
  - address defines: LAUNCH = 4, CLR_ERR = 7;
  - status field ranges: TAG [7:0], QCNT [15:8], OUT [23:16], ERR [31];
  - the packed command width macro.
- Sub-module simd_stop_cmd_fifo: a generic synchronous FIFO with
  - width NUM_REGS*DATA_W + TAG_W and depth DEPTH;
  - outputs full, empty, count, and a registered head;
  - asynchronous active-low reset.
- Top level keeps staging, tag and outstanding logic.

Test Plan:
- Write fields 0..3 = 0x11, 0x22, 0x33, 0x44, then LAUNCH, with ready = 1 -> cmd_valid one cycle after the launch edge; cmd_data = {0x44, 0x33, 0x22, 0x11}; tag = 0; status[23:16] = 1.
- Ready held 0; 5 LAUNCHes with DEPTH = 4 -> wr_ready drops after the 4th; 5th held; status[15:8] = 4. Raise ready -> 5th accepted in the cycle after the first pop; tags 0..4 issued in order.
- MAX_OUT = 4, no completes -> after 4 handshakes cmd_valid = 0 with a queued entry. One complete pulse -> cmd_valid = 1 the next cycle.
- Handshake and complete in the same cycle with outstanding = 2 -> stays 2. Complete with outstanding = 0 -> err = 1. CLR_ERR -> err = 0. Write to addr 5 -> err = 1.
- 256 LAUNCHes -> tag wraps 255 -> 0. Assert reset mid-stream with a queue of 3 and cmd_valid high -> all outputs 0 immediately; first post-reset LAUNCH carries tag 0.

Source files
------------

// File: rtl/simd_stop_cmd_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simd_stop_cmd_queue_pkg
// Purpose  : Shared constants, types and helpers for the SIMD -> streamingOps
//            command queue (regFile address map, status word layout).
// Revision : 1.0 - initial release
// ============================================================================
package simd_stop_cmd_queue_pkg;

   // regFile write address map
   localparam int unsigned                 WR_ADDR_W    = 3;
   localparam logic [WR_ADDR_W-1:0]        ADDR_LAUNCH  = 3'd4;
   localparam logic [WR_ADDR_W-1:0]        ADDR_CLR_ERR = 3'd7;

   // status word layout
   localparam int unsigned ST_FIELD_W  = 8;
   localparam int unsigned ST_TAG_LSB  = 0;
   localparam int unsigned ST_QCNT_LSB = 8;
   localparam int unsigned ST_OUT_LSB  = 16;
   localparam int unsigned ST_ERR_BIT  = 31;

   typedef enum logic [1:0] {
      WR_FIELD   = 2'd0,
      WR_LAUNCH  = 2'd1,
      WR_CLR_ERR = 2'd2,
      WR_ILLEGAL = 2'd3
   } wr_kind_e;

   // Width of the packed command payload (all staged fields side by side)
   function automatic int unsigned cmd_width(input int unsigned num_regs,
                                             input int unsigned data_w);
      return num_regs * data_w;
   endfunction

   // Classify a regFile write address
   function automatic wr_kind_e decode_wr_addr(input logic [WR_ADDR_W-1:0] addr,
                                               input int unsigned num_regs);
      wr_kind_e kind;
      if (32'(addr) < num_regs)       kind = WR_FIELD;
      else if (addr == ADDR_LAUNCH)   kind = WR_LAUNCH;
      else if (addr == ADDR_CLR_ERR)  kind = WR_CLR_ERR;
      else                            kind = WR_ILLEGAL;
      return kind;
   endfunction

endpackage
`default_nettype wire

// File: rtl/simd_stop_cmd_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : simd_stop_cmd_queue_if
// Purpose  : Bundles the SIMD regFile write port, status return and the
//            streamingOps command/completion handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface simd_stop_cmd_queue_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 4,
   parameter int TAG_W    = 8,
   parameter int PE_ID_W  = 6
);
   logic                         simd__scntl__wr_valid;
   logic                         simd__scntl__wr_ready;
   logic [2:0]                   simd__scntl__wr_addr;
   logic [DATA_W-1:0]            simd__scntl__wr_data;
   logic [DATA_W-1:0]            scntl__simd__status;
   logic                         scntl__simd__busy;
   logic                         scntl__stop__cmd_valid;
   logic                         stop__scntl__cmd_ready;
   logic [NUM_REGS*DATA_W-1:0]   scntl__stop__cmd_data;
   logic [TAG_W-1:0]             scntl__stop__cmd_tag;
   logic [PE_ID_W-1:0]           scntl__stop__cmd_peId;
   logic                         stop__scntl__complete;

   // Environment side: SIMD core plus streamingOps controller
   modport master (
      output simd__scntl__wr_valid, simd__scntl__wr_addr, simd__scntl__wr_data,
      output stop__scntl__cmd_ready, stop__scntl__complete,
      input  simd__scntl__wr_ready, scntl__simd__status, scntl__simd__busy,
      input  scntl__stop__cmd_valid, scntl__stop__cmd_data, scntl__stop__cmd_tag,
      input  scntl__stop__cmd_peId
   );

   // Command queue side
   modport slave (
      input  simd__scntl__wr_valid, simd__scntl__wr_addr, simd__scntl__wr_data,
      input  stop__scntl__cmd_ready, stop__scntl__complete,
      output simd__scntl__wr_ready, scntl__simd__status, scntl__simd__busy,
      output scntl__stop__cmd_valid, scntl__stop__cmd_data, scntl__stop__cmd_tag,
      output scntl__stop__cmd_peId
   );
endinterface
`default_nettype wire

// File: rtl/simd_stop_cmd_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : simd_stop_cmd_queue_fifo
// Purpose  : Generic synchronous FIFO with a registered head entry and
//            extra-MSB pointers so full and empty stay distinct at wrap.
// Revision : 1.0 - initial release
// ============================================================================
module simd_stop_cmd_queue_fifo #(
   parameter int WIDTH = 136,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_poweron,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] head_q, head_d;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count = wr_ptr_q - rd_ptr_q;
   assign head  = head_q;

   // Next storage/pointer state; head is re-read from the post-update view
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      head_d = mem_d[rd_ptr_d[AW-1:0]];
   end

   // State registers
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/simd_stop_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : simd_stop_cmd_queue
// Purpose  : Stages SIMD regFile fields, queues tagged commands on LAUNCH,
//            issues them to streamingOps and tracks outstanding completions.
// Revision : 1.0 - initial release
// ============================================================================
module simd_stop_cmd_queue
   import simd_stop_cmd_queue_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 4,
   parameter int DEPTH    = 4,
   parameter int MAX_OUT  = 4,
   parameter int TAG_W    = 8,
   parameter int PE_ID_W  = 6
) (
   input  logic                clk,
   input  logic                reset_poweron,
   input  logic [PE_ID_W-1:0]  peId,
   simd_stop_cmd_queue_if.slave bus
);
   localparam int CMD_W   = cmd_width(NUM_REGS, DATA_W);
   localparam int ENTRY_W = CMD_W + TAG_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int IDX_W   = $clog2(NUM_REGS);

   logic [DATA_W-1:0]  stage_q [NUM_REGS];
   logic [DATA_W-1:0]  stage_d [NUM_REGS];
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [7:0]         out_q, out_d;
   logic               err_q, err_d;
   logic               wr_ready_q, wr_ready_d;
   logic [DATA_W-1:0]  status_q, status_d;
   logic               busy_q, busy_d;

   logic               wr_fire, push, hs, complete_ok;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count, cnt_next;
   logic [ENTRY_W-1:0] fifo_din, fifo_head;
   wr_kind_e           wr_kind;

   assign wr_kind     = decode_wr_addr(bus.simd__scntl__wr_addr, NUM_REGS);
   assign wr_fire     = bus.simd__scntl__wr_valid && wr_ready_q;
   assign push        = wr_fire && (wr_kind == WR_LAUNCH) && !fifo_full;
   assign hs          = bus.scntl__stop__cmd_valid && bus.stop__scntl__cmd_ready;
   // A completion with nothing outstanding is spurious and only flags err
   assign complete_ok = bus.stop__scntl__complete && (out_q != '0);

   assign bus.scntl__stop__cmd_valid = !fifo_empty && (out_q < 8'(MAX_OUT));
   assign bus.scntl__stop__cmd_data  = fifo_head[ENTRY_W-1:TAG_W];
   assign bus.scntl__stop__cmd_tag   = fifo_head[TAG_W-1:0];
   assign bus.scntl__stop__cmd_peId  = peId;
   assign bus.simd__scntl__wr_ready  = wr_ready_q;
   assign bus.scntl__simd__status    = status_q;
   assign bus.scntl__simd__busy      = busy_q;

   // Snapshot of the staged fields with field 0 in the LSBs, tag underneath
   always_comb begin
      fifo_din              = '0;
      fifo_din[TAG_W-1:0]   = tag_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         fifo_din[TAG_W + i*DATA_W +: DATA_W] = stage_q[i];
      end
   end

   // Next staging/tag/outstanding/err state and the registered status view
   always_comb begin
      stage_d = stage_q;
      tag_d   = tag_q;
      out_d   = out_q;
      err_d   = err_q;

      if (wr_fire && (wr_kind == WR_FIELD)) begin
         stage_d[bus.simd__scntl__wr_addr[IDX_W-1:0]] = bus.simd__scntl__wr_data;
      end
      if (push) begin
         tag_d = tag_q + 1'b1;
      end

      if (hs && !complete_ok)      out_d = out_q + 8'd1;
      else if (!hs && complete_ok) out_d = out_q - 8'd1;

      // Set beats clear when both happen together
      if ((wr_fire && (wr_kind == WR_ILLEGAL)) ||
          (bus.stop__scntl__complete && (out_q == '0))) begin
         err_d = 1'b1;
      end else if (wr_fire && (wr_kind == WR_CLR_ERR)) begin
         err_d = 1'b0;
      end

      cnt_next   = fifo_count + CNT_W'(push) - CNT_W'(hs);
      wr_ready_d = (cnt_next != CNT_W'(DEPTH));

      status_d                               = '0;
      status_d[ST_TAG_LSB +: TAG_W]          = tag_d;
      status_d[ST_QCNT_LSB +: ST_FIELD_W]    = ST_FIELD_W'(cnt_next);
      status_d[ST_OUT_LSB +: ST_FIELD_W]     = out_d;
      status_d[ST_ERR_BIT]                   = err_d;
      busy_d = (cnt_next != '0) || (out_d != '0);
   end

   // State registers
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         for (int i = 0; i < NUM_REGS; i++) stage_q[i] <= '0;
         tag_q      <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
         wr_ready_q <= 1'b0;
         status_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         stage_q    <= stage_d;
         tag_q      <= tag_d;
         out_q      <= out_d;
         err_q      <= err_d;
         wr_ready_q <= wr_ready_d;
         status_q   <= status_d;
         busy_q     <= busy_d;
      end
   end

   simd_stop_cmd_queue_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (push),
      .din           (fifo_din),
      .pop           (hs),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .count         (fifo_count),
      .head          (fifo_head)
   );

endmodule
`default_nettype wire

// File: tb/tb_simd_stop_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_stop_cmd_queue
// Purpose  : Scoreboard bench for simd_stop_cmd_queue: directed scenarios
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_stop_cmd_queue;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 4;
   localparam int DEPTH    = 4;
   localparam int MAX_OUT  = 4;
   localparam int TAG_W    = 8;
   localparam int PE_ID_W  = 6;
   localparam int CMD_W    = NUM_REGS * DATA_W;

   typedef struct {
      logic [CMD_W-1:0] data;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   logic               clk           = 1'b0;
   logic               reset_poweron = 1'b0;
   logic [PE_ID_W-1:0] peId          = 6'h2b;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int                m_q, m_out, m_tag;
   bit                m_err, m_rdy;
   logic [DATA_W-1:0] m_stage [NUM_REGS];
   cmd_t              sb [$];

   always #5 clk = ~clk;

   simd_stop_cmd_queue_if #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .PE_ID_W(PE_ID_W)
   ) bus ();

   simd_stop_cmd_queue #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH),
      .MAX_OUT(MAX_OUT), .TAG_W(TAG_W), .PE_ID_W(PE_ID_W)
   ) dut (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .peId          (peId),
      .bus           (bus)
   );

   task automatic check(input string name, input logic [CMD_W-1:0] act,
                        input logic [CMD_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic check_outputs();
      logic [DATA_W-1:0] st;
      st        = '0;
      st[7:0]   = m_tag[7:0];
      st[15:8]  = m_q[7:0];
      st[23:16] = m_out[7:0];
      st[31]    = m_err;
      check("wr_ready",  bus.simd__scntl__wr_ready,  m_rdy);
      check("cmd_valid", bus.scntl__stop__cmd_valid, (m_q > 0) && (m_out < MAX_OUT));
      check("busy",      bus.scntl__simd__busy,      (m_q != 0) || (m_out != 0));
      check("status",    bus.scntl__simd__status,    st);
   endtask

   task automatic drive(input bit v, input logic [2:0] a, input logic [DATA_W-1:0] d,
                        input bit rdy, input bit cmp);
      bus.simd__scntl__wr_valid  = v;
      bus.simd__scntl__wr_addr   = a;
      bus.simd__scntl__wr_data   = d;
      bus.stop__scntl__cmd_ready = rdy;
      bus.stop__scntl__complete  = cmp;
   endtask

   // Effect of one clock edge with the given inputs, from the behavioural rules
   task automatic model_step(input bit v, input logic [2:0] a, input logic [DATA_W-1:0] d,
                             input bit rdy, input bit cmp);
      bit   acc, hs, eset, eclr;
      cmd_t c;
      acc  = v && m_rdy;
      hs   = (m_q > 0) && (m_out < MAX_OUT) && rdy;
      eset = 1'b0;
      eclr = 1'b0;
      if (acc) begin
         if (int'(a) < NUM_REGS) begin
            m_stage[a[1:0]] = d;
         end else if (a == 3'd4) begin
            for (int i = 0; i < NUM_REGS; i++) c.data[i*DATA_W +: DATA_W] = m_stage[i];
            c.tag = m_tag[TAG_W-1:0];
            sb.push_back(c);
            m_q++;
            m_tag = (m_tag + 1) % 256;
         end else if (a == 3'd7) begin
            eclr = 1'b1;
         end else begin
            eset = 1'b1;
         end
      end
      if (hs) m_q--;
      if (cmp) begin
         if (m_out == 0) eset = 1'b1;
         else            m_out--;
      end
      if (hs) m_out++;
      if (eset)      m_err = 1'b1;
      else if (eclr) m_err = 1'b0;
      m_rdy = (m_q < DEPTH);
   endtask

   task automatic step(input bit v, input logic [2:0] a, input logic [DATA_W-1:0] d,
                       input bit rdy, input bit cmp);
      @(negedge clk);
      check_outputs();
      drive(v, a, d, rdy, cmp);
      model_step(v, a, d, rdy, cmp);
   endtask

   task automatic drain();
      for (int n = 0; n < 64 && (m_q != 0 || m_out != 0); n++) step(1'b0, 3'd0, '0, 1'b1, m_out > 0);
      step(1'b0, 3'd0, '0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset between edges, with a completion pulse that must be ignored
   task automatic apply_reset();
      @(negedge clk);
      #1;
      reset_poweron = 1'b0;
      drive(1'b0, 3'd0, '0, 1'b0, 1'b1);
      #1;
      check("rst_cmd_valid", bus.scntl__stop__cmd_valid, 1'b0);
      check("rst_busy",      bus.scntl__simd__busy,      1'b0);
      check("rst_status",    bus.scntl__simd__status,    '0);
      check("rst_wr_ready",  bus.simd__scntl__wr_ready,  1'b0);
      check("rst_cmd_data",  bus.scntl__stop__cmd_data,  '0);
      check("rst_cmd_tag",   bus.scntl__stop__cmd_tag,   '0);
      m_q = 0; m_out = 0; m_tag = 0; m_err = 1'b0; m_rdy = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) m_stage[i] = '0;
      sb.delete();
      repeat (2) @(negedge clk);
      check("rst_status_hold", bus.scntl__simd__status, '0);
      drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
      reset_poweron = 1'b1;
      model_step(1'b0, 3'd0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: pops the scoreboard on every observed command handshake
   initial begin
      cmd_t e;
      forever begin
         @(negedge clk);
         #3;
         if (reset_poweron && bus.scntl__stop__cmd_valid === 1'b1 &&
             bus.stop__scntl__cmd_ready === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow at %0t: got tag 0x%0h, expected no command",
                        $time, bus.scntl__stop__cmd_tag);
            end else begin
               e = sb.pop_front();
               check("cmd_data", bus.scntl__stop__cmd_data, e.data);
               check("cmd_tag",  bus.scntl__stop__cmd_tag,  e.tag);
               check("cmd_peId", bus.scntl__stop__cmd_peId, peId);
            end
         end
      end
   end

   initial begin
      drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
      apply_reset();

      // Single command: fields 0x11..0x44 then LAUNCH
      for (int i = 0; i < NUM_REGS; i++) step(1'b1, 3'(i), 32'h11 * (i + 1), 1'b1, 1'b0);
      step(1'b1, 3'd4, 32'hdead_beef, 1'b1, 1'b0);
      repeat (2) step(1'b0, 3'd0, '0, 1'b1, 1'b0);
      drain();

      // Fill the FIFO with ready low, 5th LAUNCH held, then release ready
      step(1'b1, 3'd2, 32'h0bad_f00d, 1'b0, 1'b0);
      repeat (6) step(1'b1, 3'd4, '0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 3'd4, '0, 1'b1, 1'b0);
      // Run into the outstanding limit, then free one slot
      repeat (6) step(1'b0, 3'd0, '0, 1'b1, 1'b0);
      step(1'b0, 3'd0, '0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 3'd0, '0, 1'b1, 1'b0);

      // Handshake and completion together with two outstanding
      repeat (2) step(1'b0, 3'd0, '0, 1'b0, 1'b1);
      step(1'b1, 3'd4, '0, 1'b0, 1'b0);
      step(1'b0, 3'd0, '0, 1'b1, 1'b1);
      step(1'b0, 3'd0, '0, 1'b0, 1'b0);
      drain();

      // Error flag: spurious complete, clear, illegal addresses, set-beats-clear
      step(1'b0, 3'd0, '0, 1'b0, 1'b1);
      step(1'b1, 3'd7, '0, 1'b0, 1'b0);
      step(1'b1, 3'd5, 32'h1234_5678, 1'b0, 1'b0);
      step(1'b1, 3'd7, '0, 1'b0, 1'b1);
      step(1'b1, 3'd7, '0, 1'b0, 1'b0);
      step(1'b1, 3'd6, '0, 1'b0, 1'b0);
      step(1'b1, 3'd7, '0, 1'b0, 1'b0);
      step(1'b0, 3'd0, '0, 1'b0, 1'b0);

      // Tag wrap across 255 -> 0
      for (int i = 0; i < 260; i++) step(1'b1, 3'd4, $urandom(), 1'b1, m_out > 0);
      drain();

      // Randomized traffic
      repeat (1500) begin : g_rand
         bit                v, rdy, cmp;
         int                r;
         logic [2:0]        a;
         v   = ($urandom_range(99) < 70);
         r   = $urandom_range(99);
         if (r < 45)      a = 3'($urandom_range(NUM_REGS - 1));
         else if (r < 85) a = 3'd4;
         else if (r < 92) a = 3'd7;
         else             a = 3'(5 + $urandom_range(1));
         rdy = ($urandom_range(99) < 50);
         cmp = (m_out > 0) ? ($urandom_range(99) < 35) : ($urandom_range(99) < 3);
         step(v, a, $urandom(), rdy, cmp);
      end
      drain();

      // Reset mid-stream with three queued commands and cmd_valid high
      apply_reset();
      step(1'b1, 3'd1, 32'hcafe_0001, 1'b0, 1'b0);
      repeat (3) step(1'b1, 3'd4, '0, 1'b0, 1'b0);
      step(1'b0, 3'd0, '0, 1'b0, 1'b0);
      apply_reset();
      step(1'b1, 3'd4, '0, 1'b1, 1'b0);
      repeat (2) step(1'b0, 3'd0, '0, 1'b1, 1'b0);
      drain();

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
